seg7_scroll_scheduler: RTL and testbench

SEG7_SCROLL_SCHEDULER -- requirements
Module: seg7_scroll_scheduler

---
 rtl/seg7_scroll_scheduler.sv | 130 +++++++++++++
 tb/tb_seg7_scroll_scheduler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scroll_scheduler.sv
// Multiplexed seven-segment scan scheduler with a scrolling message buffer.
// Define SEG7_SCROLL_DEADTIME_EN to blank the digit select for the first quarter of every slot.
module seg7_scroll_scheduler #(
  parameter int N_DIGITS      = 8,
  parameter int REFRESH_LOG2  = 14,
  parameter int SCROLL_FRAMES = 32,
  parameter int MSG_DEPTH     = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_char,
  input  logic       clear,
  input  logic       scroll_en,
  output logic [7:0] abcdefgh,
  output logic [7:0] digit,
  output logic       frame_done
);

  localparam int AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {EMPTY, STATIC, SCROLL} state_t;

  state_t                  state;
  state_t                  next_state;
  logic [REFRESH_LOG2-1:0] prescaler;
  logic [2:0]              slot;
  logic [2:0]              slot_nxt;
  logic [LW-1:0]           len;
  logic [LW-1:0]           len_nxt;
  logic [AW-1:0]           offset;
  logic [7:0]              frame_cnt;
  logic [7:0]              mem [MSG_DEPTH];
  logic [7:0]              digit_q;
  logic [7:0]              seg_q;
  logic [7:0]              pos;
  logic                    tick;
  logic                    frame_tick;
  logic                    wr_en;

  assign tick       = &prescaler;
  assign slot_nxt   = (slot == 3'(N_DIGITS - 1)) ? 3'd0 : slot + 3'd1;
  assign frame_tick = tick && (slot == 3'(N_DIGITS - 1));
  assign frame_done = !reset && frame_tick;
  assign wr_ready   = !reset && !clear && (len < LW'(MSG_DEPTH));
  assign wr_en      = wr_valid && wr_ready;
  // Leftmost digit (highest index) shows the character at the current scroll offset.
  assign pos        = 8'(offset) + 8'(N_DIGITS - 1) - 8'(slot_nxt);

  always_comb begin
    len_nxt    = len;
    next_state = EMPTY;
    if (clear) begin
      len_nxt = '0;
    end else if (wr_en) begin
      len_nxt = len + LW'(1);
    end
    if (len_nxt == '0) begin
      next_state = EMPTY;
    end else if (scroll_en && (int'(len_nxt) > N_DIGITS)) begin
      next_state = SCROLL;
    end else begin
      next_state = STATIC;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler <= '0;
      slot      <= '0;
      len       <= '0;
      offset    <= '0;
      frame_cnt <= '0;
    end else begin
      prescaler <= prescaler + REFRESH_LOG2'(1);
      if (tick) begin
        slot <= slot_nxt;
      end
      len <= len_nxt;
      if (clear || state != SCROLL) begin
        offset    <= '0;
        frame_cnt <= '0;
      end else if (frame_tick) begin
        if (frame_cnt == 8'(SCROLL_FRAMES - 1)) begin
          frame_cnt <= '0;
          offset    <= ((LW'(offset) + LW'(1)) >= len) ? '0 : offset + AW'(1);
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  // Buffer storage carries no reset; only positions below len are ever displayed.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[len[AW-1:0]] <= wr_char;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || state == EMPTY) begin
      digit_q <= 8'h00;
      seg_q   <= 8'h00;
    end else if (tick) begin
      digit_q <= 8'd1 << slot_nxt;
      seg_q   <= (pos < 8'(len)) ? mem[pos[AW-1:0]] : 8'h00;
    end
  end

  assign abcdefgh = seg_q;

`ifdef SEG7_SCROLL_DEADTIME_EN
  // Top two prescaler bits are zero exactly during the first quarter of a slot.
  assign digit = (prescaler[REFRESH_LOG2-1:REFRESH_LOG2-2] == 2'b00) ? 8'h00 : digit_q;
`else
  assign digit = digit_q;
`endif

endmodule

// File: tb/tb_seg7_scroll_scheduler.sv
// Scoreboard bench for seg7_scroll_scheduler: stimulus queues expected values per clock edge,
// and a negedge monitor compares them against the DUT outputs.
module tb_seg7_scroll_scheduler;

  localparam int N_DIGITS      = 4;
  localparam int REFRESH_LOG2  = 2;
  localparam int SCROLL_FRAMES = 2;
  localparam int MSG_DEPTH     = 8;

  localparam int K_DIGIT = 0;
  localparam int K_SEG   = 1;
  localparam int K_READY = 2;
  localparam int K_FRAME = 3;

  typedef struct {
    int         edge_no;
    int         kind;
    logic [7:0] value;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_char;
  logic       clear;
  logic       scroll_en;
  logic [7:0] abcdefgh;
  logic [7:0] digit;
  logic       frame_done;

  exp_t  sb[$];
  int    checks     = 0;
  int    errors     = 0;
  int    edge_count = 0;
  string kind_name[4] = '{"digit", "abcdefgh", "wr_ready", "frame_done"};

  seg7_scroll_scheduler #(
    .N_DIGITS      (N_DIGITS),
    .REFRESH_LOG2  (REFRESH_LOG2),
    .SCROLL_FRAMES (SCROLL_FRAMES),
    .MSG_DEPTH     (MSG_DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_char    (wr_char),
    .clear      (clear),
    .scroll_en  (scroll_en),
    .abcdefgh   (abcdefgh),
    .digit      (digit),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  // Edge number since reset release; the DUT prescaler is 0 after edge 0 and slots change on multiples of 4.
  always @(posedge clock) edge_count <= reset ? 0 : edge_count + 1;

  task automatic check_output(input string name, input int at_edge,
                              input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at edge %0d: got %02h expected %02h", name, at_edge, actual, expected);
    end
  endtask

  always @(negedge clock) begin
    logic [7:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].edge_no == edge_count) begin
        case (sb[i].kind)
          K_DIGIT: act = digit;
          K_SEG:   act = abcdefgh;
          K_READY: act = {7'b0, wr_ready};
          default: act = {7'b0, frame_done};
        endcase
        check_output(kind_name[sb[i].kind], edge_count, act, sb[i].value);
        sb.delete(i);
      end else if (sb[i].edge_no < edge_count) begin
        checks++;
        errors++;
        $display("[TB] FAIL %s missed: edge %0d passed, now %0d", kind_name[sb[i].kind],
                 sb[i].edge_no, edge_count);
        sb.delete(i);
      end
    end
  end

  task automatic push(input int e, input int kind, input logic [7:0] v);
    sb.push_back('{edge_no: e, kind: kind, value: v});
  endtask

  // Digit is checked in the first clock of the slot (blank when dead time is built in) and the second.
  task automatic expect_digit(input int e, input logic [7:0] v);
`ifdef SEG7_SCROLL_DEADTIME_EN
    push(e, K_DIGIT, 8'h00);
`else
    push(e, K_DIGIT, v);
`endif
    push(e + 1, K_DIGIT, v);
  endtask

  task automatic expect_show(input int e, input logic [7:0] dig, input logic [7:0] seg);
    expect_digit(e, dig);
    push(e, K_SEG, seg);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_edge(input int target);
    int guard = 0;
    while (edge_count < target && guard < 2000) begin
      step();
      guard++;
    end
    if (edge_count < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_edge timeout: at %0d waiting for %0d", edge_count, target);
    end
  endtask

  // Drive inputs so that they are sampled at edge e.
  task automatic apply_stimulus(input int e, input logic valid, input logic [7:0] ch, input logic clr);
    wait_edge(e - 1);
    wr_valid = valid;
    wr_char  = ch;
    clear    = clr;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 400) begin
      step();
      guard++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard drain: %0d expectations never reached", sb.size());
      sb.delete();
    end
  endtask

  task automatic sync_frame(output int base);
    drain();
    while (edge_count % 16 != 0) step();
    base = edge_count;
  endtask

  task automatic push_reset_state();
    push(0, K_DIGIT, 8'h00);
    push(0, K_SEG,   8'h00);
    push(0, K_READY, 8'h00);
    push(0, K_FRAME, 8'h00);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at edge %0d", edge_count);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    reset     = 1'b1;
    wr_valid  = 1'b0;
    wr_char   = 8'h00;
    clear     = 1'b0;
    scroll_en = 1'b0;
    repeat (3) step();
    push_reset_state();
    step();
    step();
    reset = 1'b0;

    // Idle after reset: blank display, frame_done every 16 clocks.
    push(1, K_READY, 8'h01);
    for (int m = 1; m <= 4; m++) expect_show(4 * m, 8'h00, 8'h00);
    push(14, K_FRAME, 8'h00);
    push(15, K_FRAME, 8'h01);
    push(16, K_FRAME, 8'h00);
    push(31, K_FRAME, 8'h01);
    push(47, K_FRAME, 8'h01);
    push(63, K_FRAME, 8'h01);

    // Static four-character message; slot 1 sees a character written one clock before the update.
    sync_frame(base);
    expect_show(base + 4,  8'h02, 8'hBC);
    expect_show(base + 8,  8'h04, 8'hCE);
    expect_show(base + 12, 8'h08, 8'h8E);
    expect_show(base + 16, 8'h01, 8'hEE);
    expect_show(base + 20, 8'h02, 8'hBC);
    push(base + 4, K_READY, 8'h01);
    apply_stimulus(base + 1, 1'b1, 8'h8E, 1'b0);
    apply_stimulus(base + 2, 1'b1, 8'hCE, 1'b0);
    apply_stimulus(base + 3, 1'b1, 8'hBC, 1'b0);
    apply_stimulus(base + 4, 1'b1, 8'hEE, 1'b0);
    apply_stimulus(base + 5, 1'b0, 8'h00, 1'b0);

    // Fill the buffer, then hold a ninth character that must be refused.
    sync_frame(base);
    push(base,     K_READY, 8'h00);
    push(base + 1, K_READY, 8'h01);
    push(base + 8, K_READY, 8'h01);
    push(base + 9, K_READY, 8'h00);
    push(base + 12, K_READY, 8'h00);
    expect_show(base + 4,  8'h02, 8'h00);
    expect_show(base + 16, 8'h01, 8'h44);
    expect_show(base + 20, 8'h02, 8'h33);
    expect_show(base + 24, 8'h04, 8'h22);
    expect_show(base + 28, 8'h08, 8'h11);
    apply_stimulus(base + 1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) apply_stimulus(base + 2 + i, 1'b1, 8'(17 * (i + 1)), 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(base + 10 + i, 1'b1, 8'h99, 1'b0);
    apply_stimulus(base + 15, 1'b0, 8'h00, 1'b0);

    // Six characters with scrolling: offset advances every 32 clocks, past-the-end shows blank.
    sync_frame(base);
    scroll_en = 1'b1;
    expect_show(base + 12,  8'h08, 8'hA1);
    expect_show(base + 16,  8'h01, 8'hA4);
    expect_show(base + 44,  8'h08, 8'hA2);
    expect_show(base + 48,  8'h01, 8'hA5);
    expect_show(base + 76,  8'h08, 8'hA3);
    expect_show(base + 80,  8'h01, 8'hA6);
    expect_show(base + 108, 8'h08, 8'hA4);
    expect_show(base + 112, 8'h01, 8'h00);
    expect_show(base + 140, 8'h08, 8'hA5);
    expect_show(base + 144, 8'h01, 8'h00);
    expect_show(base + 172, 8'h08, 8'hA6);
    expect_show(base + 176, 8'h01, 8'h00);
    expect_show(base + 204, 8'h08, 8'hA1);
    expect_show(base + 208, 8'h01, 8'hA4);
    apply_stimulus(base + 1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) apply_stimulus(base + 2 + i, 1'b1, 8'hA1 + 8'(i), 1'b0);
    apply_stimulus(base + 8, 1'b0, 8'h00, 1'b0);

    // Clear with a simultaneous write while scrolling: message empties and the write is lost.
    sync_frame(base);
    push(base,     K_READY, 8'h00);
    push(base + 1, K_READY, 8'h01);
    expect_show(base + 4,  8'h00, 8'h00);
    expect_show(base + 8,  8'h00, 8'h00);
    expect_show(base + 12, 8'h08, 8'h66);
    expect_show(base + 16, 8'h01, 8'h00);
    push(base + 15, K_FRAME, 8'h01);
    apply_stimulus(base + 1, 1'b1, 8'h55, 1'b1);
    apply_stimulus(base + 2, 1'b0, 8'h00, 1'b0);
    apply_stimulus(base + 9, 1'b1, 8'h66, 1'b0);
    apply_stimulus(base + 10, 1'b0, 8'h00, 1'b0);

    // Reset mid-frame with a write pending: nothing may be committed.
    sync_frame(base);
    apply_stimulus(base + 6, 1'b1, 8'h77, 1'b0);
    reset = 1'b1;
    step();
    push_reset_state();
    step();
    reset    = 1'b0;
    wr_valid = 1'b0;
    push(1, K_READY, 8'h01);
    expect_show(4,  8'h00, 8'h00);
    expect_show(12, 8'h00, 8'h00);
    push(15, K_FRAME, 8'h01);

    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
